// File: rtl/sensor_acq_sequencer.sv
// Trigger-driven acquisition sequencer: pulses enabled sensors in ascending order with a
// programmable gap, gathers their done edges and bounds the whole sequence with a timeout.
module sensor_acq_sequencer #(
    parameter int N_SENS = 10,
    parameter int GAP_W  = 8,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [N_SENS-1:0] en_bits,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic [TMO_W-1:0]  timeout_cycles,
    input  logic [N_SENS-1:0] done_in,
    input  logic              clr_err,
    output logic [N_SENS-1:0] start_out,
    output logic              busy,
    output logic              seq_done,
    output logic [N_SENS-1:0] done_flags,
    output logic [N_SENS-1:0] timeout_flags,
    output logic [TMO_W-1:0]  seq_cycles,
    output logic              overrun_err
);

    // state | meaning
    // IDLE  | waiting for a trigger with a non-empty enable mask
    // ISSUE | emit one start pulse to the lowest pending channel
    // GAP   | idle spacing between consecutive start pulses
    // WAIT  | all pulses issued, waiting for done edges or timeout
    // FIN   | one-cycle end of sequence, seq_done asserted
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, FIN} state_t;

    state_t state, state_next;

    logic [N_SENS-1:0] mask;
    logic [N_SENS-1:0] pending;
    logic [N_SENS-1:0] issued;
    logic [N_SENS-1:0] done_prev;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMO_W-1:0]  elapsed;

    logic [N_SENS-1:0] rise;
    logic [N_SENS-1:0] done_upd;
    logic [N_SENS-1:0] pick;
    logic [N_SENS-1:0] pending_rest;
    logic              complete;
    logic              tmo_hit;
    logic              active;

    logic accept;
    logic issue_fire;
    logic tmo_fire;

    assign rise         = done_in & ~done_prev;
    assign done_upd     = done_flags | (rise & issued);
    assign pick         = pending & (~pending + 1'b1);
    assign pending_rest = pending & ~pick;
    assign complete     = ((done_flags & mask) == mask) && (pending == '0);
    // Timeout compares against the live input so software can extend or shorten a running sequence.
    assign tmo_hit      = (timeout_cycles != '0) && (elapsed == timeout_cycles) && !complete;
    assign active       = (state == ISSUE) || (state == GAP) || (state == WAIT);

    assign busy     = (state != IDLE);
    assign seq_done = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue_fire = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (trigger && (en_bits != '0)) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = FIN;
                end else begin
                    issue_fire = 1'b1;
                    if (pending_rest == '0)      state_next = WAIT;
                    else if (gap_cycles == '0)   state_next = ISSUE;
                    else                         state_next = GAP;
                end
            end
            GAP: begin
                if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = FIN;
                end else if (gap_cnt <= GAP_W'(1)) begin
                    state_next = ISSUE;
                end
            end
            WAIT: begin
                if (complete) begin
                    state_next = FIN;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask          <= '0;
            pending       <= '0;
            issued        <= '0;
            done_prev     <= '0;
            gap_cnt       <= '0;
            elapsed       <= '0;
            start_out     <= '0;
            done_flags    <= '0;
            timeout_flags <= '0;
            seq_cycles    <= '0;
            overrun_err   <= 1'b0;
        end else begin
            done_prev <= done_in;
            start_out <= issue_fire ? pick : '0;

            // A new overrun in the same cycle as clr_err must not be lost.
            if (trigger && (state != IDLE)) overrun_err <= 1'b1;
            else if (clr_err)               overrun_err <= 1'b0;

            if (accept) begin
                mask          <= en_bits;
                pending       <= en_bits;
                issued        <= '0;
                done_flags    <= '0;
                timeout_flags <= '0;
                elapsed       <= '0;
            end else if (active) begin
                done_flags <= done_upd;
                if (elapsed != '1) elapsed <= elapsed + 1'b1;
            end

            if (issue_fire) begin
                pending <= pending_rest;
                issued  <= issued | pick;
            end

            if ((state == ISSUE) && (state_next == GAP)) gap_cnt <= gap_cycles;
            else if (state == GAP)                       gap_cnt <= gap_cnt - 1'b1;

            // done_upd, not done_flags: a done edge coinciding with the timeout counts as done.
            if (tmo_fire)          timeout_flags <= mask & ~done_upd;
            if (state_next == FIN) seq_cycles    <= elapsed;
        end
    end

endmodule

// File: tb/tb_sensor_acq_sequencer.sv
// Directed self-checking bench for sensor_acq_sequencer with hand-computed expectations.
module tb_sensor_acq_sequencer;

    localparam int N_SENS = 10;
    localparam int GAP_W  = 8;
    localparam int TMO_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trigger;
    logic [N_SENS-1:0] en_bits;
    logic [GAP_W-1:0]  gap_cycles;
    logic [TMO_W-1:0]  timeout_cycles;
    logic [N_SENS-1:0] done_in;
    logic              clr_err;
    logic [N_SENS-1:0] start_out;
    logic              busy;
    logic              seq_done;
    logic [N_SENS-1:0] done_flags;
    logic [N_SENS-1:0] timeout_flags;
    logic [TMO_W-1:0]  seq_cycles;
    logic              overrun_err;

    int n_cmp = 0;
    int n_err = 0;
    int start_count = 0;
    int seq_done_count = 0;

    sensor_acq_sequencer #(.N_SENS(N_SENS), .GAP_W(GAP_W), .TMO_W(TMO_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trigger        (trigger),
        .en_bits        (en_bits),
        .gap_cycles     (gap_cycles),
        .timeout_cycles (timeout_cycles),
        .done_in        (done_in),
        .clr_err        (clr_err),
        .start_out      (start_out),
        .busy           (busy),
        .seq_done       (seq_done),
        .done_flags     (done_flags),
        .timeout_flags  (timeout_flags),
        .seq_cycles     (seq_cycles),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_out != '0) start_count += $countones(start_out);
        if (seq_done) seq_done_count++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_seq_done(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!seq_done && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, {31'd0, seq_done}, 32'd1);
    endtask

    logic [N_SENS-1:0] exp_start [1:9];

    initial begin
        int c0;
        int d0;
        int k;

        rst_n = 1'b0; trigger = 1'b0; en_bits = 10'h005; gap_cycles = 8'd0;
        timeout_cycles = 16'd0; done_in = '0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start",    32'(start_out), 32'h0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_seq_done", {31'd0, seq_done}, 32'd0);
        chk("rst_done_fl",  32'(done_flags), 32'h0);
        chk("rst_tmo_fl",   32'(timeout_flags), 32'h0);
        chk("rst_cycles",   32'(seq_cycles), 32'h0);
        chk("rst_overrun",  {31'd0, overrun_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back pulses with gap 0
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("t1_busy",   {31'd0, busy}, 32'd1);
        chk("t1_nostart", 32'(start_out), 32'h0);
        step(); chk("t1_start0", 32'(start_out), 32'h001);
        step(); chk("t1_start2", 32'(start_out), 32'h004);
        step(); chk("t1_start_off", 32'(start_out), 32'h000);
        done_in = 10'h005;
        step(); chk("t1_done_fl", 32'(done_flags), 32'h005);
        step();
        chk("t1_seq_done", {31'd0, seq_done}, 32'd1);
        chk("t1_cycles",   32'(seq_cycles), 32'd4);
        step();
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_seq_done_low", {31'd0, seq_done}, 32'd0);
        done_in = '0;

        // Gap of 3: pulses on ch0, ch8, ch9 four cycles apart
        en_bits = 10'h301; gap_cycles = 8'd3;
        exp_start[1] = 10'h001; exp_start[2] = '0; exp_start[3] = '0; exp_start[4] = '0;
        exp_start[5] = 10'h100; exp_start[6] = '0; exp_start[7] = '0; exp_start[8] = '0;
        exp_start[9] = 10'h200;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("t2_flags_clr", 32'(done_flags), 32'h0);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("t2_start_c%0d", i), 32'(start_out), 32'(exp_start[i]));
        end
        step(); chk("t2_start_off", 32'(start_out), 32'h0);
        done_in = 10'h301;
        step();
        step();
        chk("t2_seq_done", {31'd0, seq_done}, 32'd1);
        chk("t2_done_fl",  32'(done_flags), 32'h301);
        chk("t2_tmo_fl",   32'(timeout_flags), 32'h0);
        step();
        done_in = '0;

        // Timeout with only ch0 finishing
        en_bits = 10'h003; gap_cycles = 8'd0; timeout_cycles = 16'd50;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        k = 0;
        repeat (3) begin step(); k++; end
        done_in = 10'h001;
        while (!seq_done && k < 120) begin step(); k++; end
        chk("t3_fin_cycle", 32'(k), 32'd51);
        chk("t3_seq_done",  {31'd0, seq_done}, 32'd1);
        chk("t3_tmo_fl",    32'(timeout_flags), 32'h002);
        chk("t3_done_fl",   32'(done_flags), 32'h001);
        chk("t3_cycles",    32'(seq_cycles), 32'd50);
        step();
        chk("t3_idle", {31'd0, busy}, 32'd0);
        done_in = '0; timeout_cycles = 16'd0;

        // Overrun while busy; simultaneous clr_err loses to a new overrun
        en_bits = 10'h001;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        c0 = start_count;
        step(); chk("t4_start", 32'(start_out), 32'h001);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("t4_overrun", {31'd0, overrun_err}, 32'd1);
        done_in = 10'h001;
        wait_seq_done("t4_seq_done", 10);
        chk("t4_no_extra_start", 32'(start_count - c0), 32'd1);
        step();
        done_in = '0;
        chk("t4_overrun_sticky", {31'd0, overrun_err}, 32'd1);
        trigger = 1'b1;
        step();
        clr_err = 1'b1;
        step();
        trigger = 1'b0;
        chk("t4_clr_vs_new", {31'd0, overrun_err}, 32'd1);
        step();
        clr_err = 1'b0;
        chk("t4_cleared", {31'd0, overrun_err}, 32'd0);
        done_in = 10'h001;
        wait_seq_done("t4b_seq_done", 10);
        step();
        done_in = '0;

        // Empty mask ignored; done edges on un-issued or already-high channels ignored
        en_bits = '0;
        d0 = seq_done_count;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t5_no_seq_done", 32'(seq_done_count - d0), 32'd0);
        chk("t5_flags_kept", 32'(done_flags), 32'h001);

        en_bits = 10'h003; gap_cycles = 8'd10;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        done_in = 10'h002;
        step();
        step();
        chk("t5_unissued", 32'(done_flags), 32'h000);
        c0 = start_count;
        repeat (11) step();
        chk("t5_ch1_started", 32'(start_count - c0), 32'd1);
        chk("t5_already_high", 32'(done_flags), 32'h000);
        done_in = '0;
        step();
        done_in = 10'h003;
        step();
        chk("t5_done_fl", 32'(done_flags), 32'h003);
        wait_seq_done("t5_seq_done", 10);
        chk("t5_tmo_fl", 32'(timeout_flags), 32'h000);
        step();
        done_in = '0;

        // Reset asserted mid-GAP
        en_bits = 10'h301; gap_cycles = 8'd5;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        done_in = 10'h001;
        step();
        chk("t6_pre_done", 32'(done_flags), 32'h001);
        d0 = seq_done_count;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy",     {31'd0, busy}, 32'd0);
        chk("t6_done_fl",  32'(done_flags), 32'h0);
        chk("t6_start",    32'(start_out), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_in = '0;
        step();
        chk("t6_no_seq_done", 32'(seq_done_count - d0), 32'd0);
        en_bits = 10'h005; gap_cycles = 8'd1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step(); chk("t6_start0", 32'(start_out), 32'h001);
        step(); chk("t6_gap",    32'(start_out), 32'h000);
        step(); chk("t6_start2", 32'(start_out), 32'h004);
        done_in = 10'h005;
        wait_seq_done("t6_seq_done", 10);
        chk("t6_clean_flags", 32'(done_flags), 32'h005);
        chk("t6_one_seq_done", 32'(seq_done_count - d0 + 1), 32'd1);
        step();
        done_in = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
